// File: rtl/rs_station_pkg.sv
// Shared constants and opcode encoding for the reservation station slice.
package rs_station_pkg;

    localparam int unsigned RS_SIZE_DEF = 8;
    localparam int unsigned TAG_W_DEF   = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OP_W        = 6;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21,
        OP_AND   = 6'd22,
        OP_OR    = 6'd23,
        OP_XOR   = 6'd24,
        OP_ADDI  = 6'd30
    } opcode_e;

endpackage

// File: rtl/rs_station_prio_enc.sv
// Lowest-set-bit priority encoder: index of the first 1 in vec_i plus a found flag.
module rs_prio_enc #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i] && !found_o) begin
                idx_o   = i[IW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// Reservation station: allocates renamed ops, snoops ALU/LSB broadcasts for
// operand wakeup and issues the lowest-index fully ready entry each cycle.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_valid,
    input  logic [5:0]       in_opcode,
    input  logic [31:0]      in_imm,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_v1,
    input  logic [31:0]      in_v2,
    input  logic             in_rdy1,
    input  logic             in_rdy2,
    output logic             full,
    input  logic             alu_cdb_valid,
    input  logic [TAG_W-1:0] alu_cdb_tag,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [TAG_W-1:0] lsb_cdb_tag,
    input  logic [31:0]      lsb_cdb_val,
    input  logic             flush,
    output logic             ex_valid,
    output logic [5:0]       ex_opcode,
    output logic [31:0]      ex_a,
    output logic [31:0]      ex_b,
    output logic [31:0]      ex_imm,
    output logic [TAG_W-1:0] ex_tag
);

    localparam int unsigned IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] r1_q, r1_d;
    logic [RS_SIZE-1:0] r2_q, r2_d;
    logic [5:0]         op_q  [RS_SIZE];
    logic [5:0]         op_d  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [TAG_W-1:0]   tag_q [RS_SIZE];
    logic [TAG_W-1:0]   tag_d [RS_SIZE];
    logic [31:0]        v1_q  [RS_SIZE];
    logic [31:0]        v1_d  [RS_SIZE];
    logic [31:0]        v2_q  [RS_SIZE];
    logic [31:0]        v2_d  [RS_SIZE];

    logic               ex_valid_q, ex_valid_d;
    logic [5:0]         ex_op_q, ex_op_d;
    logic [31:0]        ex_a_q, ex_a_d;
    logic [31:0]        ex_b_q, ex_b_d;
    logic [31:0]        ex_imm_q, ex_imm_d;
    logic [TAG_W-1:0]   ex_tag_q, ex_tag_d;

    logic [IW-1:0]      free_idx, sel_idx;
    logic               free_found, sel_found;
    logic [RS_SIZE-1:0] ready_vec;
    logic [31:0]        byp_v1, byp_v2;
    logic               byp_r1, byp_r2;

    assign full      = &busy_q;
    assign ready_vec = busy_q & r1_q & r2_q;

    rs_prio_enc #(.N(RS_SIZE), .IW(IW)) u_free_enc (
        .vec_i   (~busy_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_prio_enc #(.N(RS_SIZE), .IW(IW)) u_sel_enc (
        .vec_i   (ready_vec),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    // Operand capture at dispatch; ALU is applied last so it wins a tag tie.
    always_comb begin
        byp_v1 = in_v1;
        byp_r1 = in_rdy1;
        byp_v2 = in_v2;
        byp_r2 = in_rdy2;
        if (!in_rdy1 && lsb_cdb_valid && in_v1[TAG_W-1:0] == lsb_cdb_tag) begin
            byp_v1 = lsb_cdb_val;
            byp_r1 = True;
        end
        if (!in_rdy1 && alu_cdb_valid && in_v1[TAG_W-1:0] == alu_cdb_tag) begin
            byp_v1 = alu_cdb_val;
            byp_r1 = True;
        end
        if (!in_rdy2 && lsb_cdb_valid && in_v2[TAG_W-1:0] == lsb_cdb_tag) begin
            byp_v2 = lsb_cdb_val;
            byp_r2 = True;
        end
        if (!in_rdy2 && alu_cdb_valid && in_v2[TAG_W-1:0] == alu_cdb_tag) begin
            byp_v2 = alu_cdb_val;
            byp_r2 = True;
        end
    end

    always_comb begin
        busy_d     = busy_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        op_d       = op_q;
        imm_d      = imm_q;
        tag_d      = tag_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        ex_valid_d = False;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_tag_d   = ex_tag_q;

        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
                if (!r1_q[i] && lsb_cdb_valid && v1_q[i][TAG_W-1:0] == lsb_cdb_tag) begin
                    v1_d[i] = lsb_cdb_val;
                    r1_d[i] = True;
                end
                if (!r1_q[i] && alu_cdb_valid && v1_q[i][TAG_W-1:0] == alu_cdb_tag) begin
                    v1_d[i] = alu_cdb_val;
                    r1_d[i] = True;
                end
                if (!r2_q[i] && lsb_cdb_valid && v2_q[i][TAG_W-1:0] == lsb_cdb_tag) begin
                    v2_d[i] = lsb_cdb_val;
                    r2_d[i] = True;
                end
                if (!r2_q[i] && alu_cdb_valid && v2_q[i][TAG_W-1:0] == alu_cdb_tag) begin
                    v2_d[i] = alu_cdb_val;
                    r2_d[i] = True;
                end
            end
        end

        if (sel_found) begin
            busy_d[sel_idx] = False;
            ex_valid_d      = True;
            ex_op_d         = op_q[sel_idx];
            ex_a_d          = v1_q[sel_idx];
            ex_b_d          = v2_q[sel_idx];
            ex_imm_d        = imm_q[sel_idx];
            ex_tag_d        = tag_q[sel_idx];
        end

        // Free slot comes from the pre-edge busy vector, so an issuing slot is never reused this cycle.
        if (in_valid && !full && free_found) begin
            busy_d[free_idx] = True;
            op_d[free_idx]   = in_opcode;
            imm_d[free_idx]  = in_imm;
            tag_d[free_idx]  = in_tag;
            v1_d[free_idx]   = byp_v1;
            r1_d[free_idx]   = byp_r1;
            v2_d[free_idx]   = byp_v2;
            r2_d[free_idx]   = byp_r2;
        end

        if (flush) begin
            busy_d     = '0;
            ex_valid_d = False;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q     <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            ex_valid_q <= False;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_tag_q   <= '0;
        end else if (rdy) begin
            busy_q     <= busy_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_tag_q   <= ex_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy) begin
            op_q  <= op_d;
            imm_q <= imm_d;
            tag_q <= tag_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_opcode = ex_op_q;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign ex_imm    = ex_imm_q;
    assign ex_tag    = ex_tag_q;

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: inputs change and outputs are sampled on the falling edge.
module tb_rs_station;
    import rs_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid, in_rdy1, in_rdy2, full;
    logic [5:0]  in_opcode, ex_opcode;
    logic [31:0] in_imm, in_v1, in_v2, ex_a, ex_b, ex_imm;
    logic [3:0]  in_tag, alu_cdb_tag, lsb_cdb_tag, ex_tag;
    logic        alu_cdb_valid, lsb_cdb_valid, flush, ex_valid;
    logic [31:0] alu_cdb_val, lsb_cdb_val;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    rs_station #(.RS_SIZE(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_imm(in_imm), .in_tag(in_tag),
        .in_v1(in_v1), .in_v2(in_v2), .in_rdy1(in_rdy1), .in_rdy2(in_rdy2),
        .full(full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
        .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_tag(ex_tag)
    );

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        in_valid      = 1'b0;
        in_opcode     = '0;
        in_imm        = '0;
        in_tag        = '0;
        in_v1         = '0;
        in_v2         = '0;
        in_rdy1       = 1'b0;
        in_rdy2       = 1'b0;
        alu_cdb_valid = 1'b0;
        alu_cdb_tag   = '0;
        alu_cdb_val   = '0;
        lsb_cdb_valid = 1'b0;
        lsb_cdb_tag   = '0;
        lsb_cdb_val   = '0;
        flush         = 1'b0;
    endtask

    task automatic dispatch(input logic [3:0] tag, input logic [31:0] v1, input logic r1,
                            input logic [31:0] v2, input logic r2, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_opcode = OP_ADD;
        in_tag    = tag;
        in_v1     = v1;
        in_rdy1   = r1;
        in_v2     = v2;
        in_rdy2   = r2;
        in_imm    = imm;
    endtask

    task automatic alu(input logic [3:0] tag, input logic [31:0] val);
        alu_cdb_valid = 1'b1;
        alu_cdb_tag   = tag;
        alu_cdb_val   = val;
    endtask

    task automatic lsb(input logic [3:0] tag, input logic [31:0] val);
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = tag;
        lsb_cdb_val   = val;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("rst_ex_opcode", {26'd0, ex_opcode}, 32'd0);
        check_eq("rst_ex_a", ex_a, 32'd0);
        check_eq("rst_ex_b", ex_b, 32'd0);
        check_eq("rst_ex_imm", ex_imm, 32'd0);
        check_eq("rst_ex_tag", {28'd0, ex_tag}, 32'd0);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        rst = 1'b1;

        // both operands ready: issued on the second edge, one-cycle pulse
        dispatch(4'd3, 32'd5, 1'b1, 32'd7, 1'b1, 32'h100);
        tick();
        idle();
        check_eq("t1_not_yet", {31'd0, ex_valid}, 32'd0);
        tick();
        check_eq("t1_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t1_a", ex_a, 32'd5);
        check_eq("t1_b", ex_b, 32'd7);
        check_eq("t1_tag", {28'd0, ex_tag}, 32'd3);
        check_eq("t1_imm", ex_imm, 32'h100);
        check_eq("t1_op", {26'd0, ex_opcode}, {26'd0, OP_ADD});
        tick();
        check_eq("t1_pulse_end", {31'd0, ex_valid}, 32'd0);
        check_eq("t1_a_hold", ex_a, 32'd5);

        // operand 1 waits on tag 9, woken by the ALU broadcast
        dispatch(4'd2, 32'd9, 1'b0, 32'h22, 1'b1, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_wait", {31'd0, ex_valid}, 32'd0);
            tick();
        end
        alu(4'd9, 32'h1234);
        tick();
        idle();
        check_eq("t2_wake_edge", {31'd0, ex_valid}, 32'd0);
        tick();
        check_eq("t2_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t2_a", ex_a, 32'h1234);
        check_eq("t2_b", ex_b, 32'h22);
        check_eq("t2_tag", {28'd0, ex_tag}, 32'd2);
        tick();

        // allocation-time bypass from the LSB broadcast
        dispatch(4'd6, 32'd5, 1'b0, 32'h33, 1'b1, 32'h0);
        lsb(4'd5, 32'hAB);
        tick();
        idle();
        check_eq("t3_not_yet", {31'd0, ex_valid}, 32'd0);
        tick();
        check_eq("t3_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t3_a", ex_a, 32'hAB);
        check_eq("t3_b", ex_b, 32'h33);
        check_eq("t3_tag", {28'd0, ex_tag}, 32'd6);
        tick();

        // fill all 8 entries; entry i (tag i) waits on tag 8+i
        for (int i = 0; i < 8; i++) begin
            check_eq("t4_not_full", {31'd0, full}, 32'd0);
            dispatch(i[3:0], 32'(8 + i), 1'b0, 32'h0, 1'b1, 32'h0);
            tick();
        end
        check_eq("t4_full", {31'd0, full}, 32'd1);
        dispatch(4'd15, 32'h99, 1'b1, 32'h99, 1'b1, 32'h0);
        tick();
        idle();
        check_eq("t4_drop_full", {31'd0, full}, 32'd1);
        check_eq("t4_drop_noissue", {31'd0, ex_valid}, 32'd0);
        alu(4'd12, 32'h444);
        tick();
        idle();
        check_eq("t4_full_at_wake", {31'd0, full}, 32'd1);
        tick();
        check_eq("t4_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t4_tag", {28'd0, ex_tag}, 32'd4);
        check_eq("t4_a", ex_a, 32'h444);
        check_eq("t4_full_drop", {31'd0, full}, 32'd0);
        tick();
        check_eq("t4_no_ghost", {31'd0, ex_valid}, 32'd0);

        // entries 1 and 6 woken on the same edge
        alu(4'd9, 32'h111);
        lsb(4'd14, 32'h666);
        tick();
        idle();
        tick();
        check_eq("t5_first_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t5_first_tag", {28'd0, ex_tag}, 32'd1);
        check_eq("t5_first_a", ex_a, 32'h111);
        tick();
        check_eq("t5_second_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t5_second_tag", {28'd0, ex_tag}, 32'd6);
        check_eq("t5_second_a", ex_a, 32'h666);
        tick();
        check_eq("t5_idle", {31'd0, ex_valid}, 32'd0);

        // flush with a ready entry and a ready dispatch pending
        alu(4'd8, 32'hC0);
        tick();
        idle();
        flush = 1'b1;
        dispatch(4'd9, 32'h55, 1'b1, 32'h55, 1'b1, 32'h0);
        tick();
        idle();
        check_eq("t6_flush_noissue", {31'd0, ex_valid}, 32'd0);
        check_eq("t6_flush_full", {31'd0, full}, 32'd0);
        tick();
        check_eq("t6_no_late_issue", {31'd0, ex_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_eq("t6_refill_not_full", {31'd0, full}, 32'd0);
            dispatch(i[3:0], 32'(8 + i), 1'b0, 32'h0, 1'b1, 32'h0);
            tick();
        end
        idle();
        check_eq("t6_refill_full", {31'd0, full}, 32'd1);

        // issue entry 0, then freeze with rdy=0 while stimulus is presented
        alu(4'd8, 32'hA0);
        tick();
        idle();
        tick();
        check_eq("t7_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t7_tag", {28'd0, ex_tag}, 32'd0);
        check_eq("t7_a", ex_a, 32'hA0);
        check_eq("t7_full", {31'd0, full}, 32'd0);
        rdy = 1'b0;
        alu(4'd9, 32'hB1);
        dispatch(4'd15, 32'h5, 1'b1, 32'h5, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t7_hold_valid", {31'd0, ex_valid}, 32'd1);
            check_eq("t7_hold_a", ex_a, 32'hA0);
            check_eq("t7_hold_full", {31'd0, full}, 32'd0);
        end
        rdy = 1'b1;
        idle();
        tick();
        check_eq("t7_no_wake", {31'd0, ex_valid}, 32'd0);
        check_eq("t7_no_alloc", {31'd0, full}, 32'd0);
        alu(4'd9, 32'hB1);
        tick();
        idle();
        tick();
        check_eq("t7_late_valid", {31'd0, ex_valid}, 32'd1);
        check_eq("t7_late_tag", {28'd0, ex_tag}, 32'd1);
        check_eq("t7_late_a", ex_a, 32'hB1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_station.md
# rs_station

Reservation station sitting directly downstream of the ROB dispatch path. It accepts renamed ALU/branch/jump operations, with operands either as values or as ROB tags. It snoops the ALU and LSB result broadcasts to wake up waiting operands. It issues at most one fully ready operation per cycle to the ALU, oldest-slot-first by index.

## Interface
Parameters:
- RS_SIZE, 8, number of entries (power of two)
- TAG_W, 4, ROB reorder-tag width (16-entry ROB)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low: state clears on a rising clk edge while rst==0
- rdy  in  1  global ready; when 0 all registers hold
- in_valid  in  1  dispatch request this cycle
- in_opcode  in  6  internal opcode (shared `defines.v` encoding)
- in_imm  in  32  immediate / branch target offset
- in_tag  in  TAG_W  ROB entry of this op (destination tag)
- in_v1, in_v2  in  32  operand value, or ROB tag in low TAG_W bits when not ready
- in_rdy1, in_rdy2  in  1  operand holds a value (1) or a tag (0)
- full  out  1  no free entry; dispatch must not be presented
- alu_cdb_valid  in  1  ALU broadcast valid
- alu_cdb_tag  in  TAG_W  ALU broadcast tag
- alu_cdb_val  in  32  ALU broadcast value
- lsb_cdb_valid  in  1  LSB load broadcast valid
- lsb_cdb_tag  in  TAG_W  LSB broadcast tag
- lsb_cdb_val  in  32  LSB broadcast value
- flush  in  1  mispredict/clear; discards all entries
- ex_valid  out  1  issued op valid (registered)
- ex_opcode  out  6  issued opcode
- ex_a, ex_b  out  32  issued operand values
- ex_imm  out  32  issued immediate
- ex_tag  out  TAG_W  issued op's ROB tag

## Operation
- Entry fields: busy, opcode, imm, tag, v1, v2, r1, r2.
- Allocation: when in_valid && !full && !flush, write the lowest-index non-busy entry. A dispatch presented while full is ignored.
- Allocation-time bypass: if in_rdy1==0 and a CDB in the same cycle carries tag == in_v1[TAG_W-1:0], store that value with r1=1. The same applies to operand 2. If ALU and LSB both match, the ALU value wins; they cannot legitimately carry the same tag.
- Wakeup: every busy entry with rX==0 and vX[TAG_W-1:0]==cdb_tag of a valid CDB latches cdb_val and sets rX=1. Both CDBs are processed in the same cycle.
- Select: the lowest-index busy entry with r1&&r2. Its fields go to the ex_* registers, ex_valid=1, and its busy is cleared at that edge. If no entry is ready, ex_valid=0 on the next edge; the other ex_* outputs hold.
- An entry freed by issue is reusable from the following cycle, not the same cycle.
- full = (busy count == RS_SIZE), computed combinationally from the current busy vector. Same-cycle issue does not deassert it.
- flush: at the edge, all busy=0 and ex_valid=0. Flush dominates dispatch, wakeup and issue.
- rdy==0: no allocation, wakeup or issue; all registers and outputs hold.
- Reset: all busy=0. ex_valid=0, ex_opcode=0, ex_a=0, ex_b=0, ex_imm=0, ex_tag=0, full=0.

## Timing
- Dispatch with both operands ready at edge E: entry busy after E, issued at E+1, ex_valid high during cycle E+1..E+2. Minimum residence is one cycle.
- Wakeup at edge E makes the entry eligible for issue at E+1.
- Wakeup and allocation bypass share edge E: the entry is eligible at E+1, with no lost broadcast.
- Throughput is one issue per cycle. There is no back-pressure from the ALU; ex_* is a one-cycle pulse per op.
- Reset or flush in mid-operation takes effect at that edge. Any op dispatched in the same cycle is dropped.

## Structure
- Shared package / `defines.v`:
  - opcode macros
  - RS_SIZE and TAG_W constants
  - `True`/`False`
- Sub-module rs_prio_enc: parameterized lowest-set-bit priority encoder (RS_SIZE-bit vector in; index and found flag out).
  - Instantiated twice: once for the free vector, once for the ready vector.
- Top level holds the entry arrays, wakeup comparators and ex_* registers.

## Test plan
- Reset, then dispatch ADD tag 3 with v1=5, v2=7 both ready -> two edges later ex_valid=1, ex_a=5, ex_b=7, ex_tag=3, for one cycle only.
- Dispatch tag 2 with r1=0, v1=9 (waits on tag 9). Three cycles later alu_cdb tag 9, val 0x1234 -> ex_valid on the following edge with ex_a=0x1234.
- Dispatch with r1=0 waiting on tag 5 while lsb_cdb tag 5 val 0xAB fires in the same cycle -> issues one cycle after dispatch with ex_a=0xAB.
- Fill 8 non-ready entries -> full=1. A 9th dispatch is dropped. Wake entry 4 -> it issues and full drops the cycle after.
- Entries 1 and 6 both become ready at the same edge -> entry 1 issues first, entry 6 on the next cycle.
- With 3 busy entries, pulse flush while in_valid=1 -> no issue follows, full=0, and the next dispatch lands in entry 0. Separately, holding rdy=0 for 4 cycles freezes all state and outputs.
